// File: rtl/bus_cycle_gen_if.sv
// Request/response handshake and bus control signals of the bus cycle
// generator. The multiplexed AD bus stays a plain inout port on the block.
interface bus_cycle_gen_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic        req_io;
   logic [19:0] req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;
   logic        READY;
   logic        ALE;
   logic        IOM;
   logic        RD;
   logic        WR;
   logic [11:0] A;

   // Bus cycle generator side.
   modport master (
      input  req_valid, req_write, req_io, req_addr, req_wdata, READY,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, ALE, IOM, RD, WR, A
   );

   // Requester / target side.
   modport slave (
      output req_valid, req_write, req_io, req_addr, req_wdata, READY,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, ALE, IOM, RD, WR, A
   );
endinterface

// File: rtl/bus_cycle_gen.sv
// Bus cycle generator: turns one request into a T1/T2/T3/(TW)/T4 cycle on
// a multiplexed address/data bus with wait states and a wait timeout.
module bus_cycle_gen #(
   parameter int TIMEOUT = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   bus_cycle_gen_if.master  bus,
   inout  wire  [7:0]       AD
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      T1   = 3'd1,
      T2   = 3'd2,
      T3   = 3'd3,
      TW   = 3'd4,
      T4   = 3'd5
   } state_t;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t      state_r;
   state_t      state_nxt;
   state_t      state_eff;
   logic [7:0]  wait_cnt_r;
   logic [7:0]  wait_cnt_nxt;
   logic        abort_r;
   logic        abort_nxt;
   logic [7:0]  rdata_r;
   logic [7:0]  rdata_nxt;
   logic        write_r;
   logic        io_r;
   logic [19:0] addr_r;
   logic [7:0]  wdata_r;
   logic        accept_s;
   logic        handshake_s;

   logic        ale_s;
   logic        iom_s;
   logic        rd_s;
   logic        wr_s;
   logic [11:0] a_s;
   logic        ad_oe_s;
   logic [7:0]  ad_out_s;
   logic        rsp_valid_s;

   // While RESET is high the bus looks idle regardless of the stored state.
   assign state_eff   = RESET ? IDLE : state_r;
   assign accept_s    = ((state_r == IDLE) || (state_r == T4)) && !RESET;
   assign handshake_s = accept_s && bus.req_valid;

   // Next state, wait counter, abort flag and read-data capture.
   always_comb begin
      state_nxt    = state_r;
      wait_cnt_nxt = wait_cnt_r;
      abort_nxt    = abort_r;
      rdata_nxt    = rdata_r;
      case (state_r)
         IDLE: begin
            if (handshake_s) begin
               state_nxt = T1;
            end else begin
               state_nxt = IDLE;
            end
         end
         T1: begin
            state_nxt = T2;
         end
         T2: begin
            state_nxt = T3;
         end
         T3, TW: begin
            if (bus.READY) begin
               state_nxt = T4;
               abort_nxt = 1'b0;
            end else if ((state_r == TW) && (wait_cnt_r == TIMEOUT_C)) begin
               state_nxt = T4;
               abort_nxt = 1'b1;
            end else begin
               state_nxt = TW;
            end
         end
         T4: begin
            if (handshake_s) begin
               state_nxt = T1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Counter holds the number of TW cycles including the current one.
      if (state_nxt == T1) begin
         wait_cnt_nxt = 8'd0;
         abort_nxt    = 1'b0;
      end else if (state_nxt == TW) begin
         wait_cnt_nxt = wait_cnt_r + 8'd1;
      end else begin
         wait_cnt_nxt = wait_cnt_r;
      end

      // Completion data is fixed on the edge into T4.
      if (((state_r == T3) || (state_r == TW)) && (state_nxt == T4)) begin
         if (!write_r && !abort_nxt) begin
            rdata_nxt = AD;
         end else begin
            rdata_nxt = 8'h00;
         end
      end else begin
         rdata_nxt = rdata_r;
      end
   end

   // State register and captured request; RESET abandons any cycle in flight.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r    <= IDLE;
         wait_cnt_r <= 8'd0;
         abort_r    <= 1'b0;
         rdata_r    <= 8'h00;
         write_r    <= 1'b0;
         io_r       <= 1'b0;
         addr_r     <= 20'h00000;
         wdata_r    <= 8'h00;
      end else begin
         state_r    <= state_nxt;
         wait_cnt_r <= wait_cnt_nxt;
         abort_r    <= abort_nxt;
         rdata_r    <= rdata_nxt;
         if (handshake_s) begin
            write_r <= bus.req_write;
            io_r    <= bus.req_io;
            addr_r  <= bus.req_addr;
            wdata_r <= bus.req_wdata;
         end else begin
            write_r <= write_r;
            io_r    <= io_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
         end
      end
   end

   // Bus outputs decoded from the stored state and captured request only.
   always_comb begin
      ale_s       = 1'b0;
      iom_s       = 1'b0;
      rd_s        = 1'b1;
      wr_s        = 1'b1;
      a_s         = 12'h000;
      ad_oe_s     = 1'b0;
      ad_out_s    = 8'h00;
      rsp_valid_s = 1'b0;
      case (state_eff)
         IDLE: begin
            ale_s = 1'b0;
         end
         T1: begin
            ale_s    = 1'b1;
            iom_s    = io_r;
            a_s      = addr_r[19:8];
            ad_oe_s  = 1'b1;
            ad_out_s = addr_r[7:0];
         end
         T2, T3, TW: begin
            iom_s = io_r;
            a_s   = addr_r[19:8];
            if (write_r) begin
               wr_s     = 1'b0;
               ad_oe_s  = 1'b1;
               ad_out_s = wdata_r;
            end else begin
               rd_s     = 1'b0;
               ad_oe_s  = 1'b0;
            end
         end
         T4: begin
            iom_s       = io_r;
            a_s         = addr_r[19:8];
            rsp_valid_s = 1'b1;
            if (write_r) begin
               ad_oe_s  = 1'b1;
               ad_out_s = wdata_r;
            end else begin
               ad_oe_s  = 1'b0;
            end
         end
         default: begin
            ale_s = 1'b0;
         end
      endcase
   end

   assign AD            = ad_oe_s ? ad_out_s : 8'hzz;
   assign bus.req_ready = accept_s;
   assign bus.rsp_valid = rsp_valid_s;
   assign bus.rsp_rdata = rdata_r;
   assign bus.rsp_err   = abort_r;
   assign bus.ALE       = ale_s;
   assign bus.IOM       = iom_s;
   assign bus.RD        = rd_s;
   assign bus.WR        = wr_s;
   assign bus.A         = a_s;

endmodule

// File: doc/bus_cycle_gen.md
BUS_CYCLE_GEN -- requirements
Module: bus_cycle_gen

Interface
REQ-001 Parameter: TIMEOUT, 16, maximum consecutive wait (TW) cycles before abort; legal range 1..255.
REQ-002 Port: CLK  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: RESET  in  1  reset; synchronous and active-high.
REQ-004 Port: req_valid  in  1  transaction request present.
REQ-005 Port: req_ready  out  1  block accepts a request this cycle.
REQ-006 Port: req_write  in  1  1 = write cycle, 0 = read cycle.
REQ-007 Port: req_io  in  1  1 = I/O cycle, 0 = memory cycle.
REQ-008 Port: req_addr  in  20  target address.
REQ-009 Port: req_wdata  in  8  write data.
REQ-010 Port: rsp_valid  out  1  one-cycle completion pulse.
REQ-011 Port: rsp_rdata  out  8  read data; valid with rsp_valid.
REQ-012 Port: rsp_err  out  1  timeout abort flag; valid with rsp_valid.
REQ-013 Port: READY  in  1  target ready; 0 inserts wait states.
REQ-014 Port: ALE  out  1  address latch enable, active-high.
REQ-015 Port: IOM  out  1  1 = I/O, 0 = memory.
REQ-016 Port: RD  out  1  read strobe, active-low.
REQ-017 Port: WR  out  1  write strobe, active-low.
REQ-018 Port: A  out  12  address bits [19:8].
REQ-019 Port: AD  inout  8  multiplexed address[7:0]/data bus.

Function
REQ-020 States SHALL be IDLE, T1, T2, T3, TW, T4; all bus outputs SHALL be decoded from the registered state and captured request only.
REQ-021 req_ready SHALL be 1 in IDLE and T4, 0 otherwise; a handshake (req_valid & req_ready) SHALL capture all req_* fields and move to T1 on the next edge.
REQ-022 IDLE with no handshake SHALL stay IDLE; T4 with no handshake SHALL go to IDLE; T4 with a handshake SHALL go directly to T1, giving 4 cycles per back-to-back transaction.
REQ-023 T1: ALE=1, A=addr[19:8], AD driven with addr[7:0], RD=WR=1; next state T2.
REQ-024 T2, T3, TW: ALE=0, A held; a read SHALL assert RD=0 with AD released to high-Z; a write SHALL assert WR=0 with AD driving wdata.
REQ-025 T2 SHALL always go to T3, without sampling READY.
REQ-026 T3/TW: READY=1 SHALL go to T4; READY=0 SHALL go (or stay) in TW.
REQ-027 A wait counter SHALL clear on entry to T1 and increment on each TW cycle; when READY=0 in TW with count = TIMEOUT, the block SHALL go to T4 with an abort flag set.
REQ-028 On the edge leaving T3/TW for a non-aborted read, AD SHALL be captured into rsp_rdata.
REQ-029 T4: RD=WR=1, ALE=0, A held; write SHALL keep driving wdata on AD (hold time); read SHALL release AD.
REQ-030 rsp_valid SHALL be 1 for exactly the T4 cycle; rsp_err = abort flag; rsp_rdata = 0 for writes and aborted reads.
REQ-031 IOM SHALL equal the captured req_io from T1 through T4 and SHALL be 0 in IDLE.
REQ-032 In IDLE: ALE=0, RD=WR=1, A=0, AD high-Z.
REQ-033 RD and WR SHALL never both be 0; AD SHALL never be driven while RD=0.

Reset
REQ-034 RESET=1 at a rising edge SHALL force state IDLE, clear the wait counter and abort flag, and set rsp_rdata=0 and rsp_err=0.
REQ-035 During RESET req_ready SHALL be 0 and no handshake SHALL occur; outputs SHALL equal the IDLE values of REQ-032.
REQ-036 Reset during any T-state SHALL abandon the transaction with no rsp_valid pulse.

Verification
REQ-037 Memory read, addr 0x12345, READY=1 -> T1: ALE=1, A=0x123, AD=0x45, IOM=0; T2-T3: RD=0; target drives 0xA5; T4: rsp_valid=1, rsp_rdata=0xA5, rsp_err=0.
REQ-038 I/O write, addr 0x003F8, data 0x5A -> IOM=1 T1-T4; WR=0 in T2-T3; AD=0x5A in T2-T4; T4: rsp_valid=1, rsp_rdata=0.
REQ-039 Read with READY=0 for 3 cycles -> exactly 3 TW cycles, rsp_valid 7 cycles after the handshake, data captured when READY returns to 1.
REQ-040 READY held 0, TIMEOUT=4 -> T1, T2, T3, 4 TW cycles, then T4 with rsp_err=1 and rsp_rdata=0.
REQ-041 Back-to-back: req_valid held high with 3 requests -> ALE pulses every 4 cycles, 3 rsp_valid pulses, no IDLE cycle in between.
REQ-042 RESET asserted in T3 -> next cycle IDLE outputs, no rsp_valid, and a new request is accepted normally after RESET deasserts.
